// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between an ALU (A)
// and a load/multi-cycle unit (B), with a one-entry write stage and forwarding.
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_wdat,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_wdat,
  input  logic              rf_hold,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdat,
  input  logic [ADDR_W-1:0] q_rs,
  input  logic [ADDR_W-1:0] q_rt,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rs_dat,
  output logic [DATA_W-1:0] fwd_rt_dat,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  logic              r_last;
  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_rd_p1;
  logic [DATA_W-1:0] r_wdat_p1;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic              w_open;
  logic              w_both;
  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_accept;
  logic [ADDR_W-1:0] w_acc_rd;
  logic [DATA_W-1:0] w_acc_wdat;
  logic              w_rs_hit;
  logic              w_rt_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // p0: arbitration; the requester that did not win last time has priority
  assign w_open     = !rst && !rf_hold;
  assign w_both     = a_valid && b_valid;
  assign w_a_ready  = w_open && a_valid && (!b_valid || (r_last == SEL_B));
  assign w_b_ready  = w_open && b_valid && (!a_valid || (r_last == SEL_A));
  assign w_accept   = w_a_ready || w_b_ready;
  assign w_acc_rd   = w_a_ready ? a_rd   : b_rd;
  assign w_acc_wdat = w_a_ready ? a_wdat : b_wdat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= SEL_B;
    end else if (w_accept) begin
      r_last <= w_a_ready ? SEL_A : SEL_B;
    end
  end

  // p1: write stage, frozen while the register file is held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_rd_p1   <= '0;
      r_wdat_p1 <= '0;
    end else if (!rf_hold) begin
      if (w_accept) begin
        r_vld_p1  <= (w_acc_rd != '0);
        r_rd_p1   <= w_acc_rd;
        r_wdat_p1 <= w_acc_wdat;
      end else begin
        r_vld_p1  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_both) begin
      r_conflict_cnt <= sat_inc(r_conflict_cnt);
    end
  end

  // A staged write is discarded, not emitted, while reset is asserted
  assign a_ready      = w_a_ready;
  assign b_ready      = w_b_ready;
  assign rf_wen       = r_vld_p1 && !rf_hold && !rst;
  assign rf_rd        = r_rd_p1;
  assign rf_wdat      = r_wdat_p1;
  assign conflict_cnt = r_conflict_cnt;

  assign w_rs_hit   = r_vld_p1 && (r_rd_p1 == q_rs) && (q_rs != '0);
  assign w_rt_hit   = r_vld_p1 && (r_rd_p1 == q_rt) && (q_rt != '0);
  assign fwd_rs_hit = w_rs_hit;
  assign fwd_rt_hit = w_rt_hit;
  assign fwd_rs_dat = w_rs_hit ? r_wdat_p1 : '0;
  assign fwd_rt_dat = w_rt_hit ? r_wdat_p1 : '0;

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: A (ALU result) and B (load / multi-cycle unit result).
- Arbitrates round-robin and registers the winning write into a one-entry stage that drives the register file's rd/wdat/wen inputs.
- Exposes forwarding hits for pending staged writes and a saturating conflict counter for performance monitoring.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 architectural registers)
- CNT_W, 16, width of the conflict counter

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- a_valid  input  1  requester A has a write pending
- a_ready  output  1  requester A write accepted this cycle
- a_rd  input  ADDR_W  requester A destination register
- a_wdat  input  DATA_W  requester A write data
- b_valid  input  1  requester B has a write pending
- b_ready  output  1  requester B write accepted this cycle
- b_rd  input  ADDR_W  requester B destination register
- b_wdat  input  DATA_W  requester B write data
- rf_hold  input  1  freeze the write stage; the register file must not be written
- rf_wen  output  1  register file write enable
- rf_rd  output  ADDR_W  register file write address
- rf_wdat  output  DATA_W  register file write data
- q_rs  input  ADDR_W  forwarding query, source 1
- q_rt  input  ADDR_W  forwarding query, source 2
- fwd_rs_hit  output  1  staged write matches q_rs
- fwd_rt_hit  output  1  staged write matches q_rt
- fwd_rs_dat  output  DATA_W  staged data for q_rs (valid when hit)
- fwd_rt_dat  output  DATA_W  staged data for q_rt (valid when hit)
- conflict_cnt  output  CNT_W  count of cycles with both requests valid

Behaviour:
- Handshake: a write transfers when valid & ready. Requester inputs must stay stable while valid and not ready. Ready is combinational from valid, last, rf_hold and rst.
- Arbitration state `last` (1 bit, the last accepted requester). Reset value is B, so A wins the first conflict.
  - Exactly one valid and !rf_hold: that requester gets ready=1.
  - Both valid and !rf_hold: the requester that is not `last` gets ready=1; the other gets ready=0.
  - `last` updates on every accepted transfer, including rd==0 transfers.
- At most one ready is high in any cycle. When rf_hold=1 or rst=1, both readys are 0.
- Stage (stg_valid, stg_rd, stg_wdat): when !rf_hold it loads the accepted transfer, or clears stg_valid if there is none. When rf_hold=1 its contents are retained.
- rd==0 transfer: accepted normally but loaded with stg_valid=0. It never writes and never forwards.
- Outputs:
  - rf_wen = stg_valid & !rf_hold.
  - rf_rd = stg_rd; rf_wdat = stg_wdat.
  - Latency is 1 cycle from handshake to rf_wen, when no hold is applied.
- Hold:
  - A write staged before or during a hold is presented exactly once, in the first cycle after rf_hold falls.
  - No write is lost or duplicated across a hold.
- Same rd from A and B in the same cycle: serialised in arbitration order. There is no merging; the later-accepted write wins in the register file.
- Forwarding:
  - fwd_x_hit = stg_valid & (stg_rd == q_x) & (q_x != 0).
  - fwd_x_dat = stg_wdat when hit, else 0.
  - Forwarding stays valid during hold, because the data has not yet been written.
- conflict_cnt increments in every cycle with a_valid & b_valid (hold or not). It saturates at all-ones and does not wrap.
- Reset (synchronous, rst=1 at a clock edge):
  - stg_valid=0, stg_rd=0, stg_wdat=0, last=B, conflict_cnt=0.
  - All outputs read 0 after that edge.
  - A write staged when reset asserts is dropped.
  - Requests presented while rst=1 are not accepted.

Test Plan:
- Reset, then A only (a_rd=8, a_wdat=0xDEADBEEF) -> a_ready=1 in that cycle; next cycle rf_wen=1, rf_rd=8, rf_wdat=0xDEADBEEF, and q_rs=8 gives fwd_rs_hit=1 with fwd_rs_dat=0xDEADBEEF.
- A and B both valid for 4 cycles (A: rd=16/0x1, B: rd=17/0x2) -> grants in order A,B,A,B; rf writes follow one cycle behind each grant; conflict_cnt=4.
- A with rd=0, wdat=0x55 -> a_ready=1; rf_wen stays 0; q_rs=0 gives fwd_rs_hit=0; next conflict is won by B.
- Stage A rd=9/0x77, then assert rf_hold for 3 cycles while B is valid -> rf_wen=0 and b_ready=0 throughout, fwd hit on q_rt=9 stays 1; after hold drops, rf_wen=1 with rd=9 exactly once, then B is granted.
- Hold both requests valid for 70000 cycles -> conflict_cnt=0xFFFF with no wrap.
- Assert rst on the cycle after a B grant (rd=10) -> no rf_wen for rd=10; readys are 0 during rst; after rst falls, the first conflict goes to A.
